// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable width, parity, stop bits and ratio.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around its sample point.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 tick,
  input  logic                 clear,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] out_rx,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int            SW        = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_M1   = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] FULL_M1   = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic                   bit_val;
  logic [SW-1:0]          sample_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   pe_pend, fe_pend;
  logic                   par_x, par_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // Two registered samples plus the live one form the N-2, N-1, N window.
  logic [1:0] samp_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  samp_q <= 2'b11;
    else if (tick) samp_q <= {samp_q[0], rx_s};
  end
  assign bit_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign par_x   = ^shreg ^ bit_val;
  assign par_bad = (PARITY == 1) ? ~par_x : par_x;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pe_pend    <= 1'b0;
      fe_pend    <= 1'b0;
      rdy        <= 1'b0;
      out_rx     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (clear) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (tick) begin
        case (state)
          S_IDLE: if (!rx_s) begin
            state      <= S_START;
            sample_cnt <= '0;
            pe_pend    <= 1'b0;
            fe_pend    <= 1'b0;
            busy       <= 1'b1;
          end
          S_START: begin
            if (sample_cnt == HALF_M1) begin
              if (bit_val) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state      <= S_DATA;
                sample_cnt <= '0;
                bit_cnt    <= '0;
              end
            end else sample_cnt <= sample_cnt + 1'b1;
          end
          S_DATA: begin
            if (sample_cnt == FULL_M1) begin
              sample_cnt <= '0;
              shreg      <= {bit_val, shreg[DATA_BITS-1:1]};
              bit_cnt    <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? S_PARITY : S_STOP;
              end
            end else sample_cnt <= sample_cnt + 1'b1;
          end
          S_PARITY: begin
            if (sample_cnt == FULL_M1) begin
              sample_cnt <= '0;
              pe_pend    <= par_bad;
              state      <= S_STOP;
            end else sample_cnt <= sample_cnt + 1'b1;
          end
          S_STOP: begin
            if (sample_cnt == FULL_M1) begin
              sample_cnt <= '0;
              bit_cnt    <= bit_cnt + 1'b1;
              if (!bit_val) fe_pend <= 1'b1;
              // Leave at mid-stop so the next start edge is caught with half a bit of margin.
              if (bit_cnt == LAST_STOP) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                bit_cnt    <= '0;
                out_rx     <= shreg;
                parity_err <= pe_pend;
                frame_err  <= fe_pend | ~bit_val;
                rdy        <= 1'b1;
                overrun    <= rdy & ~clear;
              end
            end else sample_cnt <= sample_cnt + 1'b1;
          end
          default: begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            sample_cnt <= '0;
            bit_cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule
